// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - log2(WIDTH)-stage barrel shifter pipeline (SLL/SRL/SRA, ROR when SHIFTER_ROTATE_EN)
// Stage k applies a 2^(SHW-1-k) bit shift; elastic valid/ready handshake with flush.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic [SHW-1:0]   i_in_amt,
    input  logic [1:0]       i_in_op,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [TAG_W-1:0] o_out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    logic [SHW-1:0]   r_v;
    logic [WIDTH-1:0] r_d   [SHW];
    logic [TAG_W-1:0] r_tag [SHW];
    // Amount and op are only consumed by later stages, so the last stage does not keep them.
    logic [SHW-1:0]   r_amt [SHW-1];
    logic [1:0]       r_op  [SHW-1];

    logic [SHW:0]     w_ld;
    logic [SHW-1:0]   w_v_in;
    logic [WIDTH-1:0] w_d_in   [SHW];
    logic [WIDTH-1:0] w_sh     [SHW];
    logic [SHW-1:0]   w_amt_in [SHW];
    logic [1:0]       w_op_in  [SHW];
    logic [TAG_W-1:0] w_tag_in [SHW];

    assign w_ld[SHW] = i_out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << (SHW - 1 - k);

        logic [WIDTH-1:0] w_sll;
        logic [WIDTH-1:0] w_srl;
        logic [WIDTH-1:0] w_sra;
        logic             w_en;

        if (k == 0) begin : g_first
            assign w_v_in[k]   = i_in_valid;
            assign w_d_in[k]   = i_in_data;
            assign w_amt_in[k] = i_in_amt;
            assign w_op_in[k]  = i_in_op;
            assign w_tag_in[k] = i_in_tag;
        end else begin : g_next
            assign w_v_in[k]   = r_v[k-1];
            assign w_d_in[k]   = r_d[k-1];
            assign w_amt_in[k] = r_amt[k-1];
            assign w_op_in[k]  = r_op[k-1];
            assign w_tag_in[k] = r_tag[k-1];
        end

        assign w_ld[k] = !r_v[k] || w_ld[k+1];
        assign w_en    = w_amt_in[k][SHW-1-k];

        assign w_sll = {w_d_in[k][WIDTH-1-S:0], {S{1'b0}}};
        assign w_srl = {{S{1'b0}}, w_d_in[k][WIDTH-1:S]};
        // Every earlier SRA stage replicated the sign, so the current MSB is the operand's sign.
        assign w_sra = {{S{w_d_in[k][WIDTH-1]}}, w_d_in[k][WIDTH-1:S]};

`ifdef SHIFTER_ROTATE_EN
        logic [WIDTH-1:0] w_ror;
        assign w_ror   = {w_d_in[k][S-1:0], w_d_in[k][WIDTH-1:S]};
        assign w_sh[k] = !w_en                  ? w_d_in[k] :
                         (w_op_in[k] == OP_SLL) ? w_sll :
                         (w_op_in[k] == OP_SRA) ? w_sra :
                         (w_op_in[k] == OP_ROR) ? w_ror : w_srl;
`else
        assign w_sh[k] = !w_en                  ? w_d_in[k] :
                         (w_op_in[k] == OP_SLL) ? w_sll :
                         (w_op_in[k] == OP_SRA) ? w_sra : w_srl;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < SHW; k++) begin
                r_d[k]   <= '0;
                r_tag[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                r_amt[k] <= '0;
                r_op[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (i_flush) begin
                    r_v[k] <= 1'b0;
                end else if (w_ld[k]) begin
                    r_v[k] <= w_v_in[k];
                end
                if (w_ld[k]) begin
                    r_d[k]   <= w_sh[k];
                    r_tag[k] <= w_tag_in[k];
                end
            end
            for (int k = 0; k < SHW - 1; k++) begin
                if (w_ld[k]) begin
                    r_amt[k] <= w_amt_in[k];
                    r_op[k]  <= w_op_in[k];
                end
            end
        end
    end

    assign o_in_ready  = w_ld[0] || i_flush;
    assign o_out_valid = r_v[SHW-1];
    assign o_out_data  = r_d[SHW-1];
    assign o_out_tag   = r_tag[SHW-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - randomized and directed bench for shifter_pipe (WIDTH=32, TAG_W=4)
module tb_shifter_pipe;

    localparam int W   = 32;
    localparam int TW  = 4;
    localparam int SHW = 5;

    logic          clk;
    logic          rst_n;
    logic          i_flush;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [W-1:0]  i_in_data;
    logic [SHW-1:0] i_in_amt;
    logic [1:0]    i_in_op;
    logic [TW-1:0] i_in_tag;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [W-1:0]  o_out_data;
    logic [TW-1:0] o_out_tag;

    shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (i_flush),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_amt    (i_in_amt),
        .i_in_op     (i_in_op),
        .i_in_tag    (i_in_tag),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_tag   (o_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    int            n_acc = 0;
    int            n_ret = 0;
    int            max_occ = 0;
    logic          stall_prev = 1'b0;
    logic [W-1:0]  prev_d;
    logic [TW-1:0] prev_t;
    logic          last_rdy;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [SHW-1:0] a,
                                               input logic [1:0] op);
        logic [2*W-1:0] dd;
        dd = {d, d} >> a;
        case (op)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return W'($signed(d) >>> a);
`ifdef SHIFTER_ROTATE_EN
            default: return dd[W-1:0];
`else
            default: return d >> a;
`endif
        endcase
    endfunction

    task automatic tick();
        exp_t e;
        logic exp_rdy;
        #1;
        exp_rdy = i_flush || i_out_ready || (q.size() < SHW);
        checks++;
        if (o_in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b want %b (occ %0d)", o_in_ready, exp_rdy, q.size());
        end
        last_rdy = o_in_ready;
        if (stall_prev) begin
            checks++;
            if (o_out_data !== prev_d || o_out_tag !== prev_t) begin
                errors++;
                $display("FAIL stall_stable: got %h/%h want %h/%h", o_out_data, o_out_tag, prev_d, prev_t);
            end
        end
        if (o_out_valid === 1'b1 && i_out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL retire: got %h/%h want no output", o_out_data, o_out_tag);
            end else begin
                e = q.pop_front();
                if (o_out_data !== e.d || o_out_tag !== e.tag) begin
                    errors++;
                    $display("FAIL retire: got %h/%h want %h/%h", o_out_data, o_out_tag, e.d, e.tag);
                end
            end
            n_ret++;
        end
        if (i_in_valid && o_in_ready === 1'b1 && !i_flush) begin
            q.push_back({ref_shift(i_in_data, i_in_amt, i_in_op), i_in_tag});
            n_acc++;
        end
        if (i_flush) q.delete();
        if (q.size() > max_occ) max_occ = q.size();
        stall_prev = (o_out_valid === 1'b1) && !i_out_ready && !i_flush;
        prev_d = o_out_data;
        prev_t = o_out_tag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        i_in_valid  = 1'b0;
        i_flush     = 1'b0;
        i_out_ready = 1'b1;
        for (int n = 0; n < 12; n++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic run_one(input logic [W-1:0] d, input logic [SHW-1:0] a, input logic [1:0] op,
                           input logic [TW-1:0] tag, input logic [W-1:0] expv, input string name);
        int lat;
        logic [W-1:0] got;
        lat = 0;
        got = 'x;
        i_in_valid = 1'b1; i_in_data = d; i_in_amt = a; i_in_op = op; i_in_tag = tag;
        i_out_ready = 1'b1; i_flush = 1'b0;
        tick();
        i_in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            #1;
            if (o_out_valid === 1'b1 && lat == 0) begin
                lat = n;
                got = o_out_data;
            end
            tick();
        end
        checks++;
        if (lat != SHW) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, SHW);
        end
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, got, expv);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_data !== '0 || o_out_tag !== '0) begin
            errors++;
            $display("FAIL %s: got v=%b r=%b d=%h t=%h want v=0 r=1 d=0 t=0",
                     name, o_out_valid, o_in_ready, o_out_data, o_out_tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_in_amt = '0;
        i_in_op = '0; i_in_tag = '0; i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_one(32'h8000_0000, 5'd31, 2'b10, 4'h1, 32'hFFFF_FFFF, "sra31");
        run_one(32'h8000_0000, 5'd31, 2'b01, 4'h2, 32'h0000_0001, "srl31");
        run_one(32'h0000_0001, 5'd31, 2'b00, 4'h3, 32'h8000_0000, "sll31");
        for (int op = 0; op < 4; op++)
            run_one(32'hDEAD_BEEF, 5'd0, 2'(op), 4'(op), 32'hDEAD_BEEF, "amt0");
`ifdef SHIFTER_ROTATE_EN
        run_one(32'h0000_0001, 5'd1, 2'b11, 4'h7, 32'h8000_0000, "ror1");
`else
        run_one(32'h0000_0001, 5'd1, 2'b11, 4'h7, 32'h0000_0000, "ror1_as_srl");
`endif
        run_one(32'h1234_5678, 5'd8, 2'b11, 4'h8, ref_shift(32'h1234_5678, 5'd8, 2'b11), "op3_amt8");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_in_valid  = ($urandom % 4) != 0;
            i_in_data   = $urandom;
            i_in_amt    = SHW'($urandom_range(0, W - 1));
            i_in_op     = 2'($urandom);
            i_in_tag    = TW'($urandom);
            i_out_ready = ($urandom % 3) != 0;
            i_flush     = ($urandom % 50) == 0;
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int base_acc;
        int base_ret;
        logic saw_drop;
        base_acc = n_acc;
        base_ret = n_ret;
        saw_drop = 1'b0;
        max_occ  = 0;
        i_flush  = 1'b0;
        for (int c = 0; c < 60 && (n_ret - base_ret) < 20; c++) begin
            i_in_valid  = (n_acc - base_acc) < 20;
            i_in_data   = $urandom;
            i_in_amt    = SHW'($urandom);
            i_in_op     = 2'($urandom);
            i_in_tag    = TW'((n_acc - base_acc) % 16);
            i_out_ready = !(c >= 3 && c <= 9);
            tick();
            if (!last_rdy) saw_drop = 1'b1;
        end
        i_in_valid = 1'b0;
        checks++;
        if (!saw_drop || max_occ != SHW) begin
            errors++;
            $display("FAIL b2b_fill: got drop=%b occ=%0d want drop=1 occ=%0d", saw_drop, max_occ, SHW);
        end
        checks++;
        if ((n_ret - base_ret) != 20 || (n_acc - base_acc) != 20) begin
            errors++;
            $display("FAIL b2b_count: got acc=%0d ret=%0d want 20/20", n_acc - base_acc, n_ret - base_ret);
        end
        drain();
    endtask

    task automatic test_flush();
        int base_ret;
        base_ret = n_ret;
        i_out_ready = 1'b1;
        i_flush = 1'b0;
        for (int n = 0; n < 3; n++) begin
            i_in_valid = 1'b1; i_in_data = $urandom; i_in_amt = SHW'($urandom);
            i_in_op = 2'($urandom); i_in_tag = TW'(n + 9);
            tick();
        end
        i_flush = 1'b1; i_in_tag = 4'hC;
        tick();
        i_flush = 1'b0; i_in_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            checks++;
            if (o_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_out_valid: got %b want 0 (cycle %0d)", o_out_valid, n + 1);
            end
            tick();
        end
        checks++;
        if (n_ret != base_ret) begin
            errors++;
            $display("FAIL flush_retire: got %0d want 0", n_ret - base_ret);
        end
    endtask

    task automatic test_reset_mid();
        i_flush = 1'b0;
        i_out_ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            i_in_valid = 1'b1; i_in_data = $urandom; i_in_amt = SHW'($urandom);
            i_in_op = 2'($urandom); i_in_tag = TW'(n);
            tick();
        end
        i_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_state");
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_one(32'h0000_0001, 5'd4, 2'b00, 4'h5, 32'h0000_0010, "post_reset_sll4");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 Derived SHW = log2(WIDTH): shift-amount width, and the number of pipeline stages.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous; clears all in-flight operations.
REQ-007 in_valid  in  1  input operation present.
REQ-008 in_ready  out  1  shifter accepts the input this cycle.
REQ-009 in_data  in  WIDTH  operand.
REQ-010 in_amt  in  SHW  shift amount, 0..WIDTH-1.
REQ-011 in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-012 in_tag  in  TAG_W  opaque tag, returned unchanged.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_data  out  WIDTH  shifted result.
REQ-016 out_tag  out  TAG_W  tag of the result.

Function
REQ-017 The shifter SHALL be a SHW-stage pipeline; stage k applies a conditional shift of 2^(SHW-1-k) bits, selected by amount bit SHW-1-k, so the MSB of the amount is applied first.
REQ-018 Each stage SHALL register its data, the remaining amount bits, the op, the tag and a valid bit.
REQ-019 Latency: an accepted operation SHALL present out_valid exactly SHW cycles after acceptance when out_ready stays high (5 cycles at WIDTH=32).
REQ-020 Handshake: a transfer SHALL occur on any cycle where valid and ready are both high; out_data and out_tag SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Stage k SHALL load when it is empty or when stage k+1 loads in the same cycle; in_ready equals the stage-0 load condition and may depend combinationally on out_ready.
REQ-022 Full throughput: with out_ready held high, one operation per cycle SHALL be accepted and retired, with no bubbles.
REQ-023 Backpressure: with out_ready low, the pipeline SHALL fill to SHW entries, then drop in_ready; no operation SHALL be lost or duplicated.
REQ-024 SLL SHALL fill vacated bits with 0; SRL SHALL fill with 0; SRA SHALL fill with the operand's original bit WIDTH-1; ROR SHALL reinsert the bits shifted out.
REQ-025 An amount of 0 SHALL pass the operand through unchanged for all ops.
REQ-026 flush SHALL clear every stage valid bit on the next edge; an input presented in the flush cycle SHALL be discarded, and in_ready SHALL be 1 during flush.
REQ-027 Results SHALL retire in acceptance order.

Reset
REQ-028 Asserting reset SHALL immediately clear all stage valid bits, so that out_valid=0 and in_ready=1.
REQ-029 While reset is asserted, out_data and out_tag SHALL be all-zero.
REQ-030 Operations in flight when reset asserts SHALL be discarded; after reset deasserts, the first accepted operation SHALL follow REQ-019 exactly.

Configuration
REQ-031 Macro SHIFTER_ROTATE_EN defined: op 11 SHALL perform ROR per REQ-024.
REQ-032 Macro SHIFTER_ROTATE_EN undefined: op 11 SHALL behave exactly as SRL, and no rotate datapath SHALL be synthesised.

Verification
REQ-033 WIDTH=32, SRA, in_data=0x80000000, amt=31 -> out_data=0xFFFFFFFF exactly 5 cycles after acceptance.
REQ-034 SRL, 0x80000000, amt=31 -> 0x00000001; SLL, 0x00000001, amt=31 -> 0x80000000; any op with amt=0 and 0xDEADBEEF -> 0xDEADBEEF.
REQ-035 With SHIFTER_ROTATE_EN: ROR, 0x00000001, amt=1 -> 0x80000000. Without SHIFTER_ROTATE_EN: the same stimulus -> 0x00000000.
REQ-036 Feed 20 back-to-back ops with tags 0..15 wrapping, holding out_ready low for cycles 3..9 -> in_ready drops after 5 entries, all 20 results retire in order with correct tags, and data is stable while stalled.
REQ-037 Flush with 3 ops in flight, plus a new op presented in the same cycle -> out_valid=0 on the next cycle, and none of those 4 ops ever appears at the output.
REQ-038 Assert reset mid-stream with a full pipeline -> out_valid=0 and in_ready=1 immediately; after release, a single SLL 0x1, amt=4 -> 0x10 at latency 5.
